// File: rtl/test_status_pkg.sv
// Shared definitions for the end-of-test monitor: status encoding and exit-convention constants.
package test_status_pkg;

  localparam int unsigned STATUS_W          = 3;
  localparam int unsigned XLEN              = 32;
  localparam int unsigned EXIT_CODE_DEFAULT = 93;
  localparam int unsigned GP_DONE           = 1;

  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } status_e;

  function automatic logic is_terminal(input status_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) || (s == ST_HANG);
  endfunction

endpackage

// File: rtl/test_status_monitor_if.sv
// Bundle between cpu_top (master) and the end-of-test monitor (slave).
interface test_status_if
  import test_status_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  logic                en;
  logic [XLEN-1:0]     a7_in;
  logic [XLEN-1:0]     gp_in;
  logic [XLEN-1:0]     a0_in;
  logic [XLEN-1:0]     pc_in;
  logic                stall_in;
  logic                done;
  logic                pass;
  logic [STATUS_W-1:0] status;
  logic [CNT_W-1:0]    cycle_count;
  logic [XLEN-1:0]     fail_value;

  modport master (
    output en, a7_in, gp_in, a0_in, pc_in, stall_in,
    input  done, pass, status, cycle_count, fail_value
  );

  modport slave (
    input  en, a7_in, gp_in, a0_in, pc_in, stall_in,
    output done, pass, status, cycle_count, fail_value
  );

endinterface

// File: rtl/test_status_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over inc.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/test_status_monitor.sv
// End-of-test monitor: latches PASS/FAIL from the riscv-tests exit ecall, or TIMEOUT/HANG.
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned HANG_CYCLES = 64,
  parameter int unsigned EXIT_CODE   = EXIT_CODE_DEFAULT,
  parameter int unsigned CNT_W       = 32
) (
  input logic         clk,
  input logic         rst,
  test_status_if.slave bus
);

  status_e          r_state;
  status_e          w_next_state;
  logic             r_done;
  logic             r_pass;
  logic [XLEN-1:0]  r_fail_value;
  logic [XLEN-1:0]  r_last_pc;
  logic [CNT_W-1:0] w_cycle_q;
  logic [CNT_W-1:0] w_hang_q;
  logic             w_exit;
  logic             w_hang_cond;
  logic             w_run_active;
  logic             w_cycle_inc;
  logic             w_hang_inc;
  logic             w_hang_clr;

  // Qualifiers and next-state; terminal states hold until reset.
  always_comb begin
    w_next_state = r_state;
    w_exit       = (bus.a7_in == XLEN'(EXIT_CODE)) && (bus.gp_in == XLEN'(GP_DONE));
    w_hang_cond  = !bus.stall_in && (bus.pc_in == r_last_pc);
    w_run_active = (r_state == ST_RUN) && bus.en;
    w_cycle_inc  = bus.en && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    w_hang_inc   = w_run_active && w_hang_cond;
    w_hang_clr   = w_run_active && !w_hang_cond;

    case (r_state)
      ST_IDLE: begin
        if (bus.en) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (bus.en) begin
          if (w_exit && (bus.a0_in == '0))                     w_next_state = ST_PASS;
          else if (w_exit)                                     w_next_state = ST_FAIL;
          else if (w_cycle_q == CNT_W'(MAX_CYCLES - 1))        w_next_state = ST_TIMEOUT;
          else if (w_hang_cond && (w_hang_q == CNT_W'(HANG_CYCLES - 1)))
                                                               w_next_state = ST_HANG;
        end
      end
      default: w_next_state = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Verdict flags follow the state; last_pc reloads on entry and whenever pc moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_value <= '0;
      r_last_pc    <= '0;
    end else begin
      r_done <= is_terminal(w_next_state);
      r_pass <= (w_next_state == ST_PASS);
      if ((r_state == ST_RUN) && (w_next_state == ST_FAIL)) begin
        r_fail_value <= bus.a0_in;
      end
      if (((r_state == ST_IDLE) && bus.en) || (w_run_active && (bus.pc_in != r_last_pc))) begin
        r_last_pc <= bus.pc_in;
      end
    end
  end

  // Cycle counter is only ever zero in IDLE, so the entry edge lands it on 1.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (w_cycle_inc),
    .q   (w_cycle_q)
  );

  sat_counter #(.W(CNT_W)) u_hang_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_hang_clr),
    .inc (w_hang_inc),
    .q   (w_hang_q)
  );

  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.status      = r_state;
  assign bus.cycle_count = w_cycle_q;
  assign bus.fail_value  = r_fail_value;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor with a per-cycle reference model and literal spot checks.
module tb_test_status_monitor;

  localparam int unsigned MAX_CYC  = 1000;
  localparam int unsigned HANG_CYC = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  test_status_if #(.CNT_W(32)) bus ();

  test_status_monitor #(
    .MAX_CYCLES  (MAX_CYC),
    .HANG_CYCLES (HANG_CYC),
    .EXIT_CODE   (93),
    .CNT_W       (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 running, 2 pass, 3 fail, 4 timeout, 5 hang.
  int          m_st   = 0;
  logic [31:0] m_cyc  = '0;
  logic [31:0] m_last = '0;
  int          m_same = 0;
  logic [31:0] m_fail = '0;

  function automatic void m_reset();
    m_st = 0; m_cyc = '0; m_last = '0; m_same = 0; m_fail = '0;
  endfunction

  function automatic void m_step();
    logic ex;
    logic same;
    if (m_st == 0) begin
      if (bus.en) begin
        m_st = 1; m_cyc = 32'd1; m_last = bus.pc_in; m_same = 0;
      end
    end else if (m_st == 1 && bus.en) begin
      ex   = (bus.a7_in == 32'd93) && (bus.gp_in == 32'd1);
      same = !bus.stall_in && (bus.pc_in == m_last);
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
      m_same = same ? m_same + 1 : 0;
      if (ex) begin
        if (bus.a0_in == 32'd0) m_st = 2;
        else begin m_st = 3; m_fail = bus.a0_in; end
      end else if (m_cyc == 32'(MAX_CYC)) m_st = 4;
      else if (m_same == int'(HANG_CYC)) m_st = 5;
      m_last = bus.pc_in;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Compare process: advance the model on every edge and check all outputs 1 ns later.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
      #1;
      chk("m_status", 32'(bus.status), 32'(m_st));
      chk("m_done",   32'(bus.done),   32'(m_st >= 2));
      chk("m_pass",   32'(bus.pass),   32'(m_st == 2));
      chk("m_count",  bus.cycle_count, m_cyc);
      chk("m_failv",  bus.fail_value,  m_fail);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic e, input logic [31:0] a7, input logic [31:0] gp,
                       input logic [31:0] a0, input logic [31:0] pc, input logic st);
    bus.en = e; bus.a7_in = a7; bus.gp_in = gp; bus.a0_in = a0;
    bus.pc_in = pc; bus.stall_in = st;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.a7_in = '0; bus.gp_in = '0; bus.a0_in = '0;
    bus.pc_in = '0; bus.stall_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_plain(input int n, inout logic [31:0] pc);
    for (int k = 0; k < n; k++) begin
      pc = pc + 32'd4;
      drive(1'b1, 32'd0, 32'd0, 32'd0, pc, 1'b0);
    end
  endtask

  logic [31:0] pc;

  initial begin
    // PASS run, with a pre-RUN exit pattern that must be ignored
    do_reset();
    chk("rst_status", 32'(bus.status), 32'd0);
    chk("rst_count",  bus.cycle_count, 32'd0);
    for (int k = 0; k < 3; k++) drive(1'b0, 32'd93, 32'd1, 32'd0, 32'h0, 1'b0);
    chk("idle_no_exit", 32'(bus.done), 32'd0);
    pc = 32'h100;
    run_plain(20, pc);
    chk("run_count20", bus.cycle_count, 32'd20);
    drive(1'b1, 32'd93, 32'd1, 32'd0, pc + 32'd4, 1'b0);
    chk("pass_status", 32'(bus.status), 32'd2);
    chk("pass_count",  bus.cycle_count, 32'd21);
    chk("pass_flag",   32'(bus.pass),   32'd1);
    run_plain(5, pc);
    chk("pass_sticky", bus.cycle_count, 32'd21);

    // FAIL run, then a0 changes after the verdict
    do_reset();
    pc = 32'h100;
    run_plain(20, pc);
    drive(1'b1, 32'd93, 32'd1, 32'd5, pc + 32'd4, 1'b0);
    chk("fail_status", 32'(bus.status), 32'd3);
    chk("fail_value",  bus.fail_value, 32'h5);
    for (int k = 0; k < 4; k++) drive(1'b1, 32'd93, 32'd1, 32'(k + 9), 32'h0, 1'b0);
    chk("fail_hold",   bus.fail_value, 32'h5);

    // TIMEOUT exactly on edge MAX_CYCLES; a7=93 with gp!=1 is not an exit
    do_reset();
    pc = 32'h200;
    for (int k = 0; k < 999; k++) begin
      pc = pc + 32'd4;
      drive(1'b1, 32'd93, 32'd2, 32'd0, pc, 1'b0);
    end
    chk("to_pre_status", 32'(bus.status), 32'd1);
    chk("to_pre_count",  bus.cycle_count, 32'd999);
    run_plain(1, pc);
    chk("to_status", 32'(bus.status), 32'd4);
    chk("to_count",  bus.cycle_count, 32'd1000);
    run_plain(50, pc);
    chk("to_frozen", bus.cycle_count, 32'd1000);

    // HANG with pc frozen and no stall
    do_reset();
    for (int k = 0; k < 64; k++) drive(1'b1, 32'd0, 32'd0, 32'd0, 32'h40, 1'b0);
    chk("hang_pre", 32'(bus.status), 32'd1);
    drive(1'b1, 32'd0, 32'd0, 32'd0, 32'h40, 1'b0);
    chk("hang_status", 32'(bus.status), 32'd5);
    chk("hang_count",  bus.cycle_count, 32'd65);

    // Alternating stall keeps a frozen pc from ever reaching HANG
    do_reset();
    for (int k = 0; k < 70; k++) drive(1'b1, 32'd0, 32'd0, 32'd0, 32'h40, 1'(k % 2));
    chk("stall_nohang", 32'(bus.status), 32'd1);

    // PASS beats TIMEOUT on the same edge
    do_reset();
    pc = 32'h300;
    run_plain(999, pc);
    drive(1'b1, 32'd93, 32'd1, 32'd0, pc + 32'd4, 1'b0);
    chk("prio_status", 32'(bus.status), 32'd2);
    chk("prio_count",  bus.cycle_count, 32'd1000);

    // Async reset mid-run, then restart counting from 1, with en=0 holding
    do_reset();
    pc = 32'h400;
    run_plain(300, pc);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_status", 32'(bus.status), 32'd0);
    chk("mid_rst_count",  bus.cycle_count, 32'd0);
    chk("mid_rst_done",   32'(bus.done),   32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("restart_count", bus.cycle_count, 32'd1);
    for (int k = 0; k < 5; k++) begin
      pc = pc + 32'd4;
      drive(1'b1, 32'd93, 32'd7, 32'd0, pc, 1'b0);
    end
    for (int k = 0; k < 3; k++) drive(1'b0, 32'd93, 32'd1, 32'd0, pc, 1'b0);
    chk("en_hold_count", bus.cycle_count, 32'd6);
    run_plain(1, pc);
    chk("en_resume", bus.cycle_count, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
